uart_rx_oversampled: RTL and testbench
======================================

UART_RX_OVERSAMPLED -- requirements
Module: uart_rx_oversampled

Interface
REQ-001 The module SHALL have parameter CLKS_PER_BIT, default 868, meaning system clocks per bit period; legal values are >= 8.
REQ-002 The module SHALL have parameter DATA_BITS, default 8, meaning data bits per frame; legal values are 5..9.
REQ-003 The module SHALL have parameter PARITY, default 0, meaning parity mode: 0 = none, 1 = odd, 2 = even.
REQ-004 The module SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame; legal values are 1 or 2.
REQ-005 Port clock, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-006 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 Port serial_connection, input, 1 bit: asynchronous serial line, idle high.
REQ-008 Port data, output, DATA_BITS bits: last received frame payload.
REQ-009 Port data_valid, output, 1 bit: held high while data holds an unacknowledged frame.
REQ-010 Port data_ack, input, 1 bit: consumer acknowledge, sampled while data_valid is high.
REQ-011 Port parity_error, output, 1 bit: parity mismatch flag for the frame in data.
REQ-012 Port framing_error, output, 1 bit: stop-bit-low flag for the frame in data.
REQ-013 Port break_detect, output, 1 bit: the frame in data had all data, parity and stop samples low.
REQ-014 Port overrun_error, output, 1 bit: sticky flag; a frame completed while data_valid was high with no data_ack.
REQ-015 Port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-016 serial_connection SHALL pass through a 2-flop synchronizer; all internal logic uses only the synchronized signal (rx_s).
REQ-017 The bit-period counter SHALL be $clog2(CLKS_PER_BIT) bits wide and SHALL restart at 0 on each bit boundary.
REQ-018 Each bit value SHALL be the majority of three samples at counter values M-1, M and M+1, where M = CLKS_PER_BIT/2 (integer division).
REQ-019 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-020 IDLE SHALL move to START in the cycle after rx_s is first seen low, with the counter cleared to 0.
REQ-021 If the START majority is 1 (false start), the FSM SHALL return to IDLE, with no output or flag change.
REQ-022 If the START majority is 0, the FSM SHALL enter DATA at the bit boundary (counter = CLKS_PER_BIT-1).
REQ-023 DATA SHALL shift DATA_BITS bits LSB first, then go to PARITY if PARITY != 0, otherwise to STOP.
REQ-024 PARITY SHALL compare the received bit against the computed value: odd parity makes data plus parity an odd count of ones; even parity makes it even.
REQ-025 STOP SHALL sample STOP_BITS bits; any stop majority of 0 sets the frame's framing error.
REQ-026 At the final stop bit's third sample (counter = M+1), the FSM SHALL return to IDLE immediately, without waiting out the bit, so that a back-to-back start edge is caught.
REQ-027 In the cycle after that final stop sample, the block SHALL load data, parity_error, framing_error and break_detect together and set data_valid to 1.
REQ-028 data_valid SHALL clear in the cycle after data_ack is sampled high while data_valid is high; the error flags clear with it, including overrun_error.
REQ-029 If a frame completes while data_valid = 1 and data_ack = 0, the new frame SHALL overwrite data and its flags, data_valid SHALL stay 1, and overrun_error SHALL be set.
REQ-030 If a frame completes in the same cycle data_ack is sampled high, the new frame SHALL load, data_valid SHALL stay 1, overrun_error SHALL be 0, and the ack applies to the old frame only.
REQ-031 data_ack while data_valid = 0 SHALL be ignored.
REQ-032 A break frame SHALL also set framing_error.

Reset
REQ-033 Asserting reset SHALL immediately force: FSM = IDLE, counters = 0, synchronizer flops = 1, data = 0, and data_valid, parity_error, framing_error, break_detect, overrun_error, busy all = 0.
REQ-034 A reset mid-frame SHALL discard the partial frame; after release, the first valid start bit is received normally.

Verification
REQ-035 Scenario, CLKS_PER_BIT=16, 8N1: send 0xAB -> data=0xAB, data_valid=1, all error flags 0; ack -> data_valid=0 next cycle.
REQ-036 Scenario: 3-cycle low glitch on an idle line -> busy pulses, FSM returns to IDLE, data_valid stays 0.
REQ-037 Scenario, PARITY=2: send 0x03 with parity bit 1 -> data=0x03, parity_error=1; with parity bit 0 -> parity_error=0.
REQ-038 Scenario: send 0x55 with stop bit 0 -> framing_error=1, break_detect=0; send an all-zero frame including stop -> break_detect=1 and framing_error=1.
REQ-039 Scenario: back-to-back 0x11 then 0x22, no ack -> data=0x22, overrun_error=1; repeat with ack coincident with the second completion -> overrun_error=0.
REQ-040 Scenario: assert reset during DATA bit 4 of 0xFF, release, send 0x5A -> data=0x5A, no flags set.

Source files
------------

// File: rtl/uart_rx_oversampled.sv
// Purpose: oversampled UART receiver; 2-flop synchronizer, majority-of-3 bit sampling, optional parity, 1/2 stop bits.
// Latency: frame results load on the clock edge that ends the final stop bit's third sample (mid stop bit + 1 clock).
// Backpressure: none on the line; an unacknowledged frame is overwritten by the next one and overrun_error is raised.
//
// Ports:
//   clock, reset          system clock (rising edge), asynchronous active-high reset
//   serial_connection     asynchronous serial input, idle high
//   data                  payload of the last completed frame
//   data_valid / data_ack frame-held flag and its consumer acknowledge
//   parity_error, framing_error, break_detect, overrun_error  status for the frame in data
//   busy                  receiver is somewhere inside a frame
module uart_rx_oversampled #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 serial_connection,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    input  logic                 data_ack,
    output logic                 parity_error,
    output logic                 framing_error,
    output logic                 break_detect,
    output logic                 overrun_error,
    output logic                 busy
);

    localparam int CW  = $clog2(CLKS_PER_BIT);
    localparam int IW  = $clog2(DATA_BITS);
    localparam int MID = CLKS_PER_BIT / 2;

    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_S0   = CW'(MID - 1);
    localparam logic [CW-1:0] CNT_S1   = CW'(MID);
    localparam logic [CW-1:0] CNT_S2   = CW'(MID + 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic                   sync_q1;
    logic                   rx_s;
    logic [CW-1:0]          cnt;
    logic [1:0]             samp;
    logic [IW-1:0]          bit_idx;
    logic                   stop_idx;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   par_q;
    logic                   stop_err_q;
    logic                   any_high_q;

    logic                   bit_end;
    logic                   at_s0;
    logic                   at_s1;
    logic                   at_s2;
    logic                   maj;
    logic                   last_data;
    logic                   last_stop;
    logic                   frame_done;
    logic                   exp_par;
    logic                   fr_perr;
    logic                   fr_ferr;
    logic                   fr_brk;

    // Two-flop synchronizer; idles high so reset does not look like a start bit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q1 <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            sync_q1 <= serial_connection;
            rx_s    <= sync_q1;
        end
    end

    assign bit_end   = (cnt == CNT_LAST);
    assign at_s0     = (cnt == CNT_S0);
    assign at_s1     = (cnt == CNT_S1);
    assign at_s2     = (cnt == CNT_S2);
    // Third sample is taken live from rx_s; the first two were latched earlier.
    assign maj       = (samp[0] & samp[1]) | (samp[0] & rx_s) | (samp[1] & rx_s);
    assign last_data = (bit_idx == IDX_LAST);
    assign last_stop = (STOP_BITS == 1) || stop_idx;
    // Leave STOP at the last stop sample so a back-to-back start edge is not missed.
    assign frame_done = (state_q == ST_STOP) && at_s2 && last_stop;

    // Odd parity: data plus parity bit has an odd count of ones.
    assign exp_par = (PARITY == 1) ? ~(^shift_q) : (^shift_q);
    assign fr_perr = (PARITY != 0) && (par_q != exp_par);
    assign fr_ferr = stop_err_q | ~maj;
    assign fr_brk  = ~(any_high_q | maj);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (at_s2 && maj) begin
                    state_d = ST_IDLE;
                end else if (bit_end) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end && last_data) begin
                    state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (frame_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bit timing and frame assembly.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            samp       <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            stop_err_q <= 1'b0;
            any_high_q <= 1'b0;
        end else begin
            if (state_q == ST_IDLE || state_d == ST_IDLE || bit_end) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end

            if (at_s0) begin
                samp[0] <= rx_s;
            end
            if (at_s1) begin
                samp[1] <= rx_s;
            end

            case (state_q)
                ST_IDLE: begin
                    bit_idx    <= '0;
                    stop_idx   <= 1'b0;
                    stop_err_q <= 1'b0;
                    any_high_q <= 1'b0;
                end
                ST_DATA: begin
                    if (at_s2) begin
                        shift_q    <= {maj, shift_q[DATA_BITS-1:1]};
                        any_high_q <= any_high_q | maj;
                    end
                    if (bit_end) begin
                        bit_idx <= last_data ? '0 : bit_idx + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (at_s2) begin
                        par_q      <= maj;
                        any_high_q <= any_high_q | maj;
                    end
                end
                ST_STOP: begin
                    if (at_s2) begin
                        stop_err_q <= stop_err_q | ~maj;
                        any_high_q <= any_high_q | maj;
                    end
                    if (bit_end) begin
                        stop_idx <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output holding register. A completing frame wins over a same-cycle ack:
    // the ack retires the old frame, so no overrun is flagged.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data          <= '0;
            data_valid    <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
            break_detect  <= 1'b0;
            overrun_error <= 1'b0;
        end else if (frame_done) begin
            data          <= shift_q;
            data_valid    <= 1'b1;
            parity_error  <= fr_perr;
            framing_error <= fr_ferr | fr_brk;
            break_detect  <= fr_brk;
            overrun_error <= data_valid & ~data_ack;
        end else if (data_valid && data_ack) begin
            data_valid    <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
            break_detect  <= 1'b0;
            overrun_error <= 1'b0;
        end
    end

    assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Purpose: scoreboard bench for uart_rx_oversampled; one 8N1 instance and one 8E1 instance, 16 clocks per bit.
// Latency: expected frames are queued as they are driven and compared once data_valid shows them.
// Backpressure: the bench drives data_ack explicitly, including the frame-completion/ack collision.
module tb_uart_rx_oversampled;

    localparam int CPB = 16;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       brk;
    } exp_t;

    logic       clock;
    logic       reset;
    logic       rx_a;
    logic       rx_p;
    logic       ack_a;
    logic       ack_p;
    logic [7:0] a_data;
    logic [7:0] p_data;
    logic       a_valid, a_perr, a_ferr, a_brk, a_ovr, a_busy;
    logic       p_valid, p_perr, p_ferr, p_brk, p_ovr, p_busy;

    exp_t sb_q[$];
    exp_t e_drop;
    int   n_tests;
    int   n_fail;
    logic saw_busy;

    uart_rx_oversampled #(
        .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
    ) dut_a (
        .clock(clock), .reset(reset), .serial_connection(rx_a),
        .data(a_data), .data_valid(a_valid), .data_ack(ack_a),
        .parity_error(a_perr), .framing_error(a_ferr), .break_detect(a_brk),
        .overrun_error(a_ovr), .busy(a_busy)
    );

    uart_rx_oversampled #(
        .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)
    ) dut_p (
        .clock(clock), .reset(reset), .serial_connection(rx_p),
        .data(p_data), .data_valid(p_valid), .data_ack(ack_p),
        .parity_error(p_perr), .framing_error(p_ferr), .break_detect(p_brk),
        .overrun_error(p_ovr), .busy(p_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_bit(input bit sel, input logic v);
        #1;
        if (sel) rx_p = v; else rx_a = v;
        repeat (CPB) @(posedge clock);
    endtask

    // sel=1 targets the even-parity instance; pbit is only sent there.
    task automatic send_frame(input bit sel, input logic [7:0] d, input logic pbit,
                              input logic sbit, input bit push);
        exp_t e;
        if (push) begin
            e.data = d;
            e.perr = sel ? ^{d, pbit} : 1'b0;
            e.ferr = ~sbit;
            e.brk  = (d == 8'h00) && (!sel || !pbit) && !sbit;
            sb_q.push_back(e);
        end
        drive_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
        if (sel) drive_bit(sel, pbit);
        drive_bit(sel, sbit);
    endtask

    task automatic idle(input bit sel, input int n);
        #1;
        if (sel) rx_p = 1'b1; else rx_a = 1'b1;
        repeat (n) @(posedge clock);
    endtask

    task automatic ack(input bit sel);
        @(posedge clock);
        #1;
        if (sel) ack_p = 1'b1; else ack_a = 1'b1;
        @(posedge clock);
        #1;
        ack_a = 1'b0;
        ack_p = 1'b0;
    endtask

    task automatic expect_frame(input bit sel, input string tag, input logic exp_ovr);
        exp_t e;
        int   n;
        n = 0;
        while (((sel ? p_valid : a_valid) !== 1'b1) && n < 400) begin
            @(negedge clock);
            n++;
        end
        @(negedge clock);
        chk({tag, "_valid"}, sel ? p_valid : a_valid, 1);
        chk({tag, "_sb_nonempty"}, sb_q.size() != 0, 1);
        if (sb_q.size() == 0) return;
        e = sb_q.pop_front();
        chk({tag, "_data"}, sel ? p_data : a_data, e.data);
        chk({tag, "_perr"}, sel ? p_perr : a_perr, e.perr);
        chk({tag, "_ferr"}, sel ? p_ferr : a_ferr, e.ferr);
        chk({tag, "_brk"},  sel ? p_brk  : a_brk,  e.brk);
        chk({tag, "_ovr"},  sel ? p_ovr  : a_ovr,  exp_ovr);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b1;
        rx_a  = 1'b1;
        rx_p  = 1'b1;
        ack_a = 1'b0;
        ack_p = 1'b0;

        repeat (3) @(negedge clock);
        chk("rst_a", {a_data, a_valid, a_perr, a_ferr, a_brk, a_ovr, a_busy}, 0);
        chk("rst_p", {p_data, p_valid, p_perr, p_ferr, p_brk, p_ovr, p_busy}, 0);
        @(posedge clock);
        #1 reset = 1'b0;
        repeat (10) @(posedge clock);

        // Plain 8N1 frame and acknowledge.
        send_frame(0, 8'hAB, 1'b0, 1'b1, 1);
        idle(0, 4);
        expect_frame(0, "ab", 1'b0);
        ack(0);
        @(negedge clock);
        chk("ab_ack_valid", a_valid, 0);

        // Ack with nothing held is ignored.
        ack(0);
        @(negedge clock);
        chk("stray_ack_valid", a_valid, 0);
        chk("stray_ack_ovr", a_ovr, 0);

        // 3-cycle glitch: false start.
        @(posedge clock);
        #1 rx_a = 1'b0;
        repeat (3) @(posedge clock);
        #1 rx_a = 1'b1;
        saw_busy = 1'b0;
        repeat (30) begin
            @(negedge clock);
            saw_busy = saw_busy | a_busy;
        end
        chk("glitch_busy_seen", saw_busy, 1);
        chk("glitch_idle", a_busy, 0);
        chk("glitch_valid", a_valid, 0);

        // Framing error, then a full break.
        send_frame(0, 8'h55, 1'b0, 1'b0, 1);
        idle(0, 4);
        expect_frame(0, "frm", 1'b0);
        ack(0);
        idle(0, 40);
        send_frame(0, 8'h00, 1'b0, 1'b0, 1);
        idle(0, 4);
        expect_frame(0, "brk", 1'b0);
        ack(0);
        @(negedge clock);
        chk("brk_ack_flags", {a_valid, a_ferr, a_brk}, 0);
        idle(0, 40);

        // Back-to-back, no ack: second overwrites and flags overrun.
        @(posedge clock);
        fork
            begin
                send_frame(0, 8'h11, 1'b0, 1'b1, 1);
                send_frame(0, 8'h22, 1'b0, 1'b1, 1);
            end
            expect_frame(0, "b2b1", 1'b0);
        join
        idle(0, 4);
        expect_frame(0, "b2b2", 1'b1);
        ack(0);
        @(negedge clock);
        chk("ovr_clr", {a_valid, a_ovr}, 0);
        idle(0, 20);

        // Back-to-back with ack landing on the second completion edge:
        // start low after edge 160, rx_s low 2 edges later, START at edge 163,
        // stop-bit third sample in the cycle after edge 163+144+9, load at edge 317.
        @(posedge clock);
        fork
            begin
                send_frame(0, 8'h11, 1'b0, 1'b1, 1);
                send_frame(0, 8'h22, 1'b0, 1'b1, 1);
            end
            begin
                repeat (316) @(posedge clock);
                #1 ack_a = 1'b1;
                @(posedge clock);
                #1 ack_a = 1'b0;
            end
        join
        idle(0, 4);
        e_drop = sb_q.pop_front();   // 0x11 was retired by the coincident ack
        expect_frame(0, "coin", 1'b0);
        ack(0);

        // Even parity instance.
        send_frame(1, 8'h03, 1'b1, 1'b1, 1);
        idle(1, 4);
        expect_frame(1, "par1", 1'b0);
        ack(1);
        send_frame(1, 8'h03, 1'b0, 1'b1, 1);
        idle(1, 4);
        expect_frame(1, "par0", 1'b0);
        ack(1);
        @(negedge clock);
        chk("par_ack_valid", p_valid, 0);
        idle(0, 20);

        // Reset in the middle of data bit 4 of 0xFF (DUT bit 5 spans edges 83..98).
        @(posedge clock);
        fork
            send_frame(0, 8'hFF, 1'b0, 1'b1, 0);
            begin
                repeat (88) @(posedge clock);
                #2 reset = 1'b1;
                @(negedge clock);
                chk("midrst_a", {a_data, a_valid, a_perr, a_ferr, a_brk, a_ovr, a_busy}, 0);
                repeat (2) @(posedge clock);
                #2 reset = 1'b0;
            end
        join
        idle(0, 20);
        @(negedge clock);
        chk("midrst_discard", {a_valid, a_busy}, 0);
        send_frame(0, 8'h5A, 1'b0, 1'b1, 1);
        idle(0, 4);
        expect_frame(0, "after_rst", 1'b0);
        chk("sb_drained", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
